ps2_key_tracker: RTL
====================

# ps2_key_tracker

Front end of the keyboard path. Deserialises the PS/2 keyboard line, parses make/break/extended scan-code sequences, and maintains a 512-bit key-state bitmap with a change strobe. Drives the key decoder stage directly: that stage samples `key_down` whenever `key_valid` is high.

## Interface
- `FILTER_LEN`, 8: number of consecutive `clk` cycles a synchronised `ps2_clk` level must hold before it is accepted.
- `TIMEOUT_CYC`, 100000: idle `clk` cycles inside a frame before the partial frame is dropped.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- `ps2_clk`  in  1  raw PS/2 clock from the pad, asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the pad, asynchronous.
- `key_down`  out  512  key-state bitmap, indexed by 9-bit code {ext, scan byte}.
- `last_change`  out  9  code of the most recent bitmap change.
- `key_valid`  out  1  one-cycle strobe: bitmap and `last_change` were just updated.
- `frame_err`  out  1  one-cycle strobe: received frame discarded.

## Operation
- Receiver:
  - 2-flop synchronisers on both pads.
  - `ps2_clk` is glitch-filtered per `FILTER_LEN`.
  - Data is sampled on each falling edge of the filtered clock.
  - Frame is 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
  - Start bit = 1: abort silently and re-arm. This is not a frame error.
  - Stop bit = 0: discard the frame and pulse `frame_err`.
  - Parity handling is set by the macro (see Configuration).
  - A complete good frame produces an internal `byte_valid` strobe with an 8-bit `byte`.
- Timeout: a bit counter that is nonzero and sees no falling edge for `TIMEOUT_CYC` cycles returns to 0. The partial frame is dropped and `frame_err` does not pulse.
- Parser FSM with states IDLE, EXT, BRK and EXT_BRK:
  - IDLE: E0 → EXT; F0 → BRK; E1 → IDLE (discarded, Pause not supported); any other byte b → make {0,b} → IDLE.
  - EXT: F0 → EXT_BRK; E0 or E1 → EXT (ignored); b → make {1,b} → IDLE.
  - BRK: b → break {0,b} → IDLE. A prefix byte E0/F0/E1 here → IDLE with no action.
  - EXT_BRK: b → break {1,b} → IDLE. A prefix byte here → IDLE with no action.
- Make sets `key_down[code]`. Break clears `key_down[code]`.
- `key_valid` pulses and `last_change` loads only when the bit actually changes:
  - Typematic repeats of a held key produce no strobe.
  - A break for a key not held produces no strobe.
- Multiple keys may be held simultaneously; only the bit addressed by the current event is touched.
- Reset values:
  - Outputs: `key_down`=0, `last_change`=0, `key_valid`=0, `frame_err`=0.
  - Internal: FSM IDLE, bit counter 0, filter and synchronisers cleared to idle-high.
- A reset asserted mid-frame discards the partial frame.

## Timing
- Filter latency: 2 synchroniser cycles + `FILTER_LEN` cycles from a pad edge to the filtered edge.
- `byte_valid` is asserted the cycle after the filtered falling edge that samples the stop bit.
- Bitmap update, `last_change` and `key_valid` are all registered in the cycle after `byte_valid`. All three are visible in that same cycle.
- `frame_err` is asserted the cycle after the falling edge that samples the offending bit.
- `key_valid` and `frame_err` are single-cycle pulses and are never both high.
- Throughput: at most one byte per frame (~1 ms); no backpressure.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - A frame whose parity does not give odd parity over data+parity is discarded.
  - `frame_err` pulses and there is no `byte_valid`.
- Not defined:
  - The parity bit is clocked in and ignored.
  - The frame is accepted whenever start and stop bits are correct.

## Structure
- Package `ps2_pkg` holds:
  - Constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_PAUSE`=8'hE1 and `KEY_CODE_W`=9.
  - The parser state enum.
- Sub-module `ps2_rx` contains the synchronisers, filter, falling-edge detector, bit counter, timeout, frame checks and the macro-controlled parity logic.
- Outputs of `ps2_rx`: `byte`, `byte_valid`, `frame_err`.
- The top level holds the parser FSM and the bitmap.

## Test plan
- Hold `reset`=0 for 3 cycles, then release → `key_down`=0, `last_change`=0, `key_valid`=0; no strobes with the line idle-high.
- Send 0x1C → `key_down[9'h01C]`=1, `last_change`=9'h01C, one-cycle `key_valid`. Then send F0 1C → bit cleared, `last_change`=9'h01C, one strobe.
- Send E0 75 → `key_down[9'h175]`=1 and `key_down[9'h075]`=0. Then send E0 F0 75 → bit 9'h175 cleared.
- Send 1C 1C 1C, then 23 → exactly two `key_valid` pulses total; bits 9'h01C and 9'h023 both set.
- Send 0x1C with wrong parity → with `PS2_PARITY_CHECK_EN`: `frame_err` pulse, bitmap unchanged. Without the macro: `key_down[9'h01C]`=1.
- Stop `ps2_clk` after 4 bits for `TIMEOUT_CYC`+10 cycles, then send a full frame 0x23 → only `key_down[9'h023]`=1 and no `frame_err`. Repeat with `reset` pulsed mid-frame → same result.

Source files
------------

// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants and parser state encoding for the PS/2 keyboard front end.
package ps2_pkg;

    localparam logic [7:0]  PS2_EXT    = 8'hE0;
    localparam logic [7:0]  PS2_BRK    = 8'hF0;
    localparam logic [7:0]  PS2_PAUSE  = 8'hE1;
    localparam int unsigned KEY_CODE_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } parse_state_e;

endpackage

// File: rtl/ps2_key_tracker_rx.sv
// PS/2 frame receiver: synchronisers, clock glitch filter, bit framing and timeout.
// Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    sclk_q, sdat_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    sr_q, sr_d;
    logic [TW-1:0] tocnt_q, tocnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          bv_q, bv_d;
    logic          fe_q, fe_d;
`ifdef PS2_PARITY_CHECK_EN
    logic          par_q, par_d;
`endif
    logic          fall;
    logic          din;

    assign din  = sdat_q[1];
    assign fall = filt_prev_q & ~filt_q;

    // The filtered clock only follows the synchronised pad after it differs for FILTER_LEN cycles.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sclk_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = sclk_q[1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        tocnt_d  = tocnt_q;
        byte_d   = byte_q;
        bv_d     = 1'b0;
        fe_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d    = par_q;
`endif
        if (fall) begin
            tocnt_d = '0;
            if (bitcnt_q == 4'd0) begin
                if (!din) bitcnt_d = 4'd1;
            end else if (bitcnt_q <= 4'd8) begin
                sr_d     = {din, sr_q[7:1]};
                bitcnt_d = bitcnt_q + 4'd1;
            end else if (bitcnt_q == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
                par_d    = din;
`endif
                bitcnt_d = 4'd10;
            end else begin
                bitcnt_d = 4'd0;
                if (!din) begin
                    fe_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                end else if (!(^{sr_q, par_q})) begin
                    fe_d = 1'b1;
`endif
                end else begin
                    bv_d   = 1'b1;
                    byte_d = sr_q;
                end
            end
        end else if (bitcnt_q != 4'd0) begin
            // A stalled partial frame is dropped quietly.
            if (tocnt_q == TW'(TIMEOUT_CYC - 1)) begin
                bitcnt_d = 4'd0;
                tocnt_d  = '0;
            end else begin
                tocnt_d = tocnt_q + 1'b1;
            end
        end else begin
            tocnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sclk_q      <= '1;
            sdat_q      <= '1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            bitcnt_q    <= '0;
            sr_q        <= '0;
            tocnt_q     <= '0;
            byte_q      <= '0;
            bv_q        <= 1'b0;
            fe_q        <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q       <= 1'b0;
`endif
        end else begin
            sclk_q      <= {sclk_q[0], ps2_clk_i};
            sdat_q      <= {sdat_q[0], ps2_data_i};
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            bitcnt_q    <= bitcnt_d;
            sr_q        <= sr_d;
            tocnt_q     <= tocnt_d;
            byte_q      <= byte_d;
            bv_q        <= bv_d;
            fe_q        <= fe_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q       <= par_d;
`endif
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = bv_q;
    assign frame_err_o  = fe_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard tracker: scan-code parser and 512-bit key-state bitmap.
// Optional parity checking in the receiver via PS2_PARITY_CHECK_EN.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    output logic [511:0]          key_down,
    output logic [KEY_CODE_W-1:0] last_change,
    output logic                  key_valid,
    output logic                  frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_i        (clk),
        .rst_ni       (reset),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (frame_err)
    );

    parse_state_e          state_q, state_d;
    logic                  ev_valid, ev_make;
    logic [KEY_CODE_W-1:0] ev_code;
    logic                  is_prefix;

    logic [511:0]          key_down_q, key_down_d;
    logic [KEY_CODE_W-1:0] last_q, last_d;
    logic                  kv_q, kv_d;

    assign is_prefix = (rx_byte == PS2_EXT) || (rx_byte == PS2_BRK) || (rx_byte == PS2_PAUSE);

    always_comb begin
        state_d  = state_q;
        ev_valid = 1'b0;
        ev_make  = 1'b0;
        ev_code  = '0;
        if (rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_byte == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_byte == PS2_BRK) begin
                        state_d = ST_BRK;
                    end else if (rx_byte != PS2_PAUSE) begin
                        ev_valid = 1'b1;
                        ev_make  = 1'b1;
                        ev_code  = {1'b0, rx_byte};
                    end
                end
                ST_EXT: begin
                    if (rx_byte == PS2_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_byte != PS2_EXT && rx_byte != PS2_PAUSE) begin
                        state_d  = ST_IDLE;
                        ev_valid = 1'b1;
                        ev_make  = 1'b1;
                        ev_code  = {1'b1, rx_byte};
                    end
                end
                ST_BRK: begin
                    state_d  = ST_IDLE;
                    ev_valid = !is_prefix;
                    ev_code  = {1'b0, rx_byte};
                end
                ST_EXT_BRK: begin
                    state_d  = ST_IDLE;
                    ev_valid = !is_prefix;
                    ev_code  = {1'b1, rx_byte};
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Only a real bit transition is reported; repeats and stray breaks stay silent.
    always_comb begin
        key_down_d = key_down_q;
        last_d     = last_q;
        kv_d       = 1'b0;
        if (ev_valid && (key_down_q[ev_code] != ev_make)) begin
            key_down_d[ev_code] = ev_make;
            last_d              = ev_code;
            kv_d                = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            key_down_q <= '0;
            last_q     <= '0;
            kv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_down_q <= key_down_d;
            last_q     <= last_d;
            kv_q       <= kv_d;
        end
    end

    assign key_down    = key_down_q;
    assign last_change = last_q;
    assign key_valid   = kv_q;

endmodule
